spi_slave_core: RTL and testbench

- SPI slave endpoint, the counterpart of the on-chip SPI master; lets the design answer an external SPI master.
- Oversamples SCLK_IN, SS_IN and MOSI_IN on master_clock through synchronizers and detects edges.
- Shifts words in and out in the configured CPOL/CPHA mode.
- Exposes valid/ready handshakes on the TX side and valid/ack handshakes on the RX side to the local logic.

---
 rtl/spi_slave_core.sv | 223 ++++++++++++++++++++++
 tb/tb_spi_slave_core.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_core.sv
// -----------------------------------------------------------------------------
// spi_slave_core
//
// SPI slave endpoint. SCLK_IN, SS_IN and MOSI_IN are oversampled on
// master_clock through two-flop synchronizers, and SCLK edges are detected
// against a third flop. Words of SPI_WORD_LEN bits are shifted in and out in
// the CPOL/CPHA mode chosen by parameter.
//
// Handshakes:
//   TX: the holding register takes tx_word on any cycle where
//       tx_valid && tx_ready. tx_ready is high while the holding register is
//       empty.
//   RX: rx_valid rises together with a new rx_word and stays high until
//       rx_ack. An rx_ack while rx_valid is low has no effect.
//
// Ports:
//   master_clock, i_rst_n        system clock and asynchronous active-low reset
//   SCLK_IN, SS_IN, MOSI_IN      SPI pins from the external master
//   MISO_OUT, MISO_OE            serial data out and its pad enable
//   tx_word/tx_valid/tx_ready    transmit holding-register handshake
//   tx_underrun                  one-cycle pulse: a word started with no TX data
//   rx_word/rx_valid/rx_ack      received-word handshake
//   busy                         a transfer is active
//   rx_overrun                   sticky overrun flag (optional feature)
//
// Optional feature macro: SPI_SLAVE_RX_OVERRUN_EN
// -----------------------------------------------------------------------------
module spi_slave_core #(
    parameter logic                    CPOL              = 1'b0,
    parameter logic                    CPHA              = 1'b0,
    parameter logic                    INVERT_DATA_ORDER = 1'b0,
    parameter int                      SPI_WORD_LEN      = 16,
    parameter logic [SPI_WORD_LEN-1:0] IDLE_PATTERN      = '1
) (
    input  logic                    master_clock,
    input  logic                    i_rst_n,
    input  logic                    SCLK_IN,
    input  logic                    SS_IN,
    input  logic                    MOSI_IN,
    output logic                    MISO_OUT,
    output logic                    MISO_OE,
    input  logic [SPI_WORD_LEN-1:0] tx_word,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    output logic                    tx_underrun,
    output logic [SPI_WORD_LEN-1:0] rx_word,
    output logic                    rx_valid,
    input  logic                    rx_ack,
    output logic                    busy,
    output logic                    rx_overrun
);

    localparam int CW = $clog2(SPI_WORD_LEN + 1);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    state_t                  state_q;
    logic [2:0]              sclk_q;       // [1] synchronized, [2] edge reference
    logic [2:0]              ss_q;
    logic [1:0]              mosi_q;
    logic [SPI_WORD_LEN-1:0] hold_q;
    logic                    hold_full_q;
    logic [SPI_WORD_LEN-1:0] tx_shift_q;
    logic [SPI_WORD_LEN-1:0] rx_shift_q;
    logic [SPI_WORD_LEN-1:0] rx_word_q;
    logic                    rx_valid_q;
    logic [CW-1:0]           bit_cnt_q;
    logic                    first_edge_q;
    logic                    tx_underrun_q;
    logic                    ur_pend_q;    // reload used IDLE_PATTERN; report when that word starts

    logic                    sclk_edge, lead_edge, trail_edge;
    logic                    sample_edge, shift_edge;
    logic                    ss_fall, ss_high;
    logic                    word_done;
    logic [SPI_WORD_LEN-1:0] rx_shift_d;
    logic [SPI_WORD_LEN-1:0] tx_shift_d;
    logic                    tx_out_bit;

    assign sclk_edge   = sclk_q[1] ^ sclk_q[2];
    assign lead_edge   = sclk_edge && (sclk_q[1] != CPOL);
    assign trail_edge  = sclk_edge && (sclk_q[1] == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge  : trail_edge;
    assign ss_fall     = ss_q[2] && !ss_q[1];
    assign ss_high     = ss_q[1];
    assign word_done   = sample_edge && (bit_cnt_q == CW'(SPI_WORD_LEN - 1));

    always_comb begin
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        tx_out_bit = 1'b0;
        if (INVERT_DATA_ORDER) begin
            rx_shift_d = {mosi_q[1], rx_shift_q[SPI_WORD_LEN-1:1]};
            tx_shift_d = {1'b0, tx_shift_q[SPI_WORD_LEN-1:1]};
            tx_out_bit = tx_shift_q[0];
        end else begin
            rx_shift_d = {rx_shift_q[SPI_WORD_LEN-2:0], mosi_q[1]};
            tx_shift_d = {tx_shift_q[SPI_WORD_LEN-2:0], 1'b0};
            tx_out_bit = tx_shift_q[SPI_WORD_LEN-1];
        end
    end

    assign busy        = (state_q == ST_ACTIVE);
    assign MISO_OE     = (state_q == ST_ACTIVE);
    assign MISO_OUT    = (state_q == ST_ACTIVE) && tx_out_bit;
    assign tx_ready    = !hold_full_q;
    assign tx_underrun = tx_underrun_q;
    assign rx_word     = rx_word_q;
    assign rx_valid    = rx_valid_q;

`ifdef SPI_SLAVE_RX_OVERRUN_EN
    logic rx_overrun_q;
    assign rx_overrun = rx_overrun_q;

    always_ff @(posedge master_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_overrun_q <= 1'b0;
        end else if (state_q == ST_ACTIVE && !ss_high && word_done
                     && rx_valid_q && !rx_ack) begin
            rx_overrun_q <= 1'b1;
        end else if (rx_ack) begin
            rx_overrun_q <= 1'b0;
        end
    end
`else
    assign rx_overrun = 1'b0;
`endif

    always_ff @(posedge master_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            sclk_q        <= {3{CPOL}};
            // SS sync resets low so that SS already low at reset release
            // is not mistaken for a falling edge.
            ss_q          <= 3'b000;
            mosi_q        <= 2'b00;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            rx_word_q     <= '0;
            rx_valid_q    <= 1'b0;
            bit_cnt_q     <= '0;
            first_edge_q  <= 1'b0;
            tx_underrun_q <= 1'b0;
            ur_pend_q     <= 1'b0;
        end else begin
            tx_underrun_q <= 1'b0;
            sclk_q        <= {sclk_q[1:0], SCLK_IN};
            ss_q          <= {ss_q[1:0], SS_IN};
            mosi_q        <= {mosi_q[0], MOSI_IN};

            if (tx_valid && !hold_full_q) begin
                hold_q      <= tx_word;
                hold_full_q <= 1'b1;
            end

            if (rx_ack) begin
                rx_valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (ss_fall) begin
                        if (hold_full_q) begin
                            tx_shift_q  <= hold_q;
                            hold_full_q <= 1'b0;
                        end else begin
                            tx_shift_q    <= IDLE_PATTERN;
                            tx_underrun_q <= 1'b1;
                        end
                        bit_cnt_q    <= '0;
                        ur_pend_q    <= 1'b0;
                        // CPHA=1 has a leading edge before the first sample;
                        // bit 0 is already on MISO, so that shift is skipped.
                        first_edge_q <= CPHA;
                        state_q      <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (ss_high) begin
                        state_q   <= ST_IDLE;
                        bit_cnt_q <= '0;
                        ur_pend_q <= 1'b0;
                    end else if (sample_edge) begin
                        rx_shift_q <= rx_shift_d;
                        if (ur_pend_q) begin
                            tx_underrun_q <= 1'b1;
                            ur_pend_q     <= 1'b0;
                        end
                        if (word_done) begin
                            rx_word_q  <= rx_shift_d;
                            rx_valid_q <= 1'b1;
                            bit_cnt_q  <= '0;
                            if (hold_full_q) begin
                                tx_shift_q  <= hold_q;
                                hold_full_q <= 1'b0;
                            end else begin
                                tx_shift_q <= IDLE_PATTERN;
                                ur_pend_q  <= 1'b1;
                            end
                            // The shift edge after a reload still belongs to
                            // the finished word; skipping it keeps the new
                            // bit 0 on MISO for the next sample.
                            first_edge_q <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CW'(1);
                        end
                    end else if (shift_edge) begin
                        if (first_edge_q) begin
                            first_edge_q <= 1'b0;
                        end else begin
                            tx_shift_q <= tx_shift_d;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_core.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_core
//
// Three instances share the clock and reset:
//   u0: mode 0, 16-bit    u1: mode 3, 16-bit    u2: mode 0, 8-bit
// The bench acts as the SPI master with an SCLK period of 8 master_clock
// cycles, driving pins on the falling edge of master_clock.
// -----------------------------------------------------------------------------
module tb_spi_slave_core;

    logic        master_clock = 1'b0;
    logic        i_rst_n      = 1'b0;
    logic [2:0]  sclk  = 3'b010;
    logic [2:0]  ss    = 3'b111;
    logic [2:0]  mosi  = 3'b000;
    logic [2:0]  txv   = 3'b000;
    logic [2:0]  rxack = 3'b000;
    logic [15:0] txw0 = '0, txw1 = '0;
    logic [7:0]  txw2 = '0;
    wire  [2:0]  miso, miso_oe, txr, txu, rxv, busy, ovr;
    wire  [15:0] rxw0, rxw1;
    wire  [7:0]  rxw2;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    int unr_cnt[3];
    int rxv_rise[3];
    logic [2:0] rxv_d = 3'b000;

    always #5 master_clock = ~master_clock;

    spi_slave_core #(.CPOL(1'b0), .CPHA(1'b0), .SPI_WORD_LEN(16)) u0 (
        .master_clock(master_clock), .i_rst_n(i_rst_n),
        .SCLK_IN(sclk[0]), .SS_IN(ss[0]), .MOSI_IN(mosi[0]),
        .MISO_OUT(miso[0]), .MISO_OE(miso_oe[0]),
        .tx_word(txw0), .tx_valid(txv[0]), .tx_ready(txr[0]), .tx_underrun(txu[0]),
        .rx_word(rxw0), .rx_valid(rxv[0]), .rx_ack(rxack[0]),
        .busy(busy[0]), .rx_overrun(ovr[0]));

    spi_slave_core #(.CPOL(1'b1), .CPHA(1'b1), .SPI_WORD_LEN(16)) u1 (
        .master_clock(master_clock), .i_rst_n(i_rst_n),
        .SCLK_IN(sclk[1]), .SS_IN(ss[1]), .MOSI_IN(mosi[1]),
        .MISO_OUT(miso[1]), .MISO_OE(miso_oe[1]),
        .tx_word(txw1), .tx_valid(txv[1]), .tx_ready(txr[1]), .tx_underrun(txu[1]),
        .rx_word(rxw1), .rx_valid(rxv[1]), .rx_ack(rxack[1]),
        .busy(busy[1]), .rx_overrun(ovr[1]));

    spi_slave_core #(.CPOL(1'b0), .CPHA(1'b0), .SPI_WORD_LEN(8)) u2 (
        .master_clock(master_clock), .i_rst_n(i_rst_n),
        .SCLK_IN(sclk[2]), .SS_IN(ss[2]), .MOSI_IN(mosi[2]),
        .MISO_OUT(miso[2]), .MISO_OE(miso_oe[2]),
        .tx_word(txw2), .tx_valid(txv[2]), .tx_ready(txr[2]), .tx_underrun(txu[2]),
        .rx_word(rxw2), .rx_valid(rxv[2]), .rx_ack(rxack[2]),
        .busy(busy[2]), .rx_overrun(ovr[2]));

    // Event counters for underrun pulses and rx_valid rising edges.
    always @(posedge master_clock) begin
        for (int i = 0; i < 3; i++) begin
            if (txu[i] === 1'b1) unr_cnt[i]++;
            if (rxv[i] === 1'b1 && rxv_d[i] !== 1'b1) rxv_rise[i]++;
        end
        rxv_d = rxv;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] rx_of(input int k);
        case (k)
            0:       rx_of = {16'h0, rxw0};
            1:       rx_of = {16'h0, rxw1};
            default: rx_of = {24'h0, rxw2};
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge master_clock);
    endtask

    task automatic load_tx(input int k, input logic [15:0] w);
        if (k == 0) txw0 = w;
        else if (k == 1) txw1 = w;
        else txw2 = w[7:0];
        txv[k] = 1'b1;
        cycles(1);
        txv[k] = 1'b0;
    endtask

    task automatic ss_lo(input int k);
        ss[k] = 1'b0;
        cycles(8);
    endtask

    task automatic ss_hi(input int k);
        cycles(4);
        ss[k] = 1'b1;
        cycles(8);
    endtask

    task automatic do_ack(input int k);
        rxack[k] = 1'b1;
        cycles(1);
        rxack[k] = 1'b0;
    endtask

    // Master side of nbits bit-times, MSB first; returns MISO bits read.
    task automatic xfer(input int k, input logic [31:0] w, input int nbits,
                        output logic [31:0] got);
        int   wl;
        logic cpol, cpha, b;
        wl   = (k == 2) ? 8 : 16;
        cpol = (k == 1);
        cpha = (k == 1);
        got  = '0;
        for (int i = 0; i < nbits; i++) begin
            b = w[wl-1-i];
            if (!cpha) begin
                mosi[k] = b;
                cycles(4);
                got     = {got[30:0], miso[k]};
                sclk[k] = ~cpol;
                cycles(4);
                sclk[k] = cpol;
            end else begin
                sclk[k] = ~cpol;
                mosi[k] = b;
                cycles(4);
                got     = {got[30:0], miso[k]};
                sclk[k] = cpol;
                cycles(4);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        i_rst_n = 1'b0;
        cycles(3);
        n_vec++;
        if ({miso, miso_oe, busy, txu, rxv, ovr} !== 18'h0) begin
            n_err++;
            $display("FAIL reset_outs: got %h required 0", {miso, miso_oe, busy, txu, rxv, ovr});
        end
        n_vec++;
        if (txr !== 3'b111) begin
            n_err++;
            $display("FAIL reset_tx_ready: got %b required 111", txr);
        end
        n_vec++;
        if ({rxw0, rxw1, rxw2} !== 40'h0) begin
            n_err++;
            $display("FAIL reset_rx_word: got %h required 0", {rxw0, rxw1, rxw2});
        end
        i_rst_n = 1'b1;
        cycles(4);
    endtask

    task automatic test_mode(input int k);
        logic [31:0] got, exp;
        int u0c, r0c;
        load_tx(k, 16'hA5C3);
        n_vec++;
        if (txr[k] !== 1'b0) begin
            n_err++;
            $display("FAIL m%0d_tx_ready_full: got %b required 0", k, txr[k]);
        end
        u0c = unr_cnt[k];
        r0c = rxv_rise[k];
        ss_lo(k);
        n_vec++;
        if ({txr[k], busy[k], miso_oe[k]} !== 3'b111) begin
            n_err++;
            $display("FAIL m%0d_after_ss_fall: ready/busy/oe got %b required 111", k, {txr[k], busy[k], miso_oe[k]});
        end
        exp_q.push_back(32'h3C5A);
        xfer(k, 32'h3C5A, 16, got);
        n_vec++;
        if (got[15:0] !== 16'hA5C3) begin
            n_err++;
            $display("FAIL m%0d_miso: got %h required a5c3", k, got[15:0]);
        end
        cycles(6);
        exp = exp_q.pop_front();
        n_vec++;
        if (rxv[k] !== 1'b1 || rx_of(k) !== exp) begin
            n_err++;
            $display("FAIL m%0d_rx: valid %b word %h required 1 %h", k, rxv[k], rx_of(k), exp);
        end
        n_vec++;
        if (rxv_rise[k] - r0c !== 1 || unr_cnt[k] - u0c !== 0) begin
            n_err++;
            $display("FAIL m%0d_counts: rx_valid sets %0d underruns %0d required 1 0", k, rxv_rise[k] - r0c, unr_cnt[k] - u0c);
        end
        do_ack(k);
        n_vec++;
        if (rxv[k] !== 1'b0) begin
            n_err++;
            $display("FAIL m%0d_ack: rx_valid %b required 0", k, rxv[k]);
        end
        ss_hi(k);
        n_vec++;
        if ({busy[k], miso_oe[k], miso[k]} !== 3'b000) begin
            n_err++;
            $display("FAIL m%0d_idle: busy/oe/miso %b required 000", k, {busy[k], miso_oe[k], miso[k]});
        end
    endtask

    task automatic test_underrun;
        logic [31:0] got;
        int u0c;
        u0c = unr_cnt[0];
        ss_lo(0);
        xfer(0, 32'h0F0F, 16, got);
        n_vec++;
        if (got[15:0] !== 16'hFFFF) begin
            n_err++;
            $display("FAIL underrun_miso: got %h required ffff", got[15:0]);
        end
        ss_hi(0);
        n_vec++;
        if (unr_cnt[0] - u0c !== 1) begin
            n_err++;
            $display("FAIL underrun_pulses: got %0d required 1", unr_cnt[0] - u0c);
        end
        do_ack(0);
    endtask

    task automatic test_ss_abort;
        logic [31:0] got, exp;
        int r0c;
        r0c = rxv_rise[0];
        ss_lo(0);
        xfer(0, 32'hFFFF, 7, got);
        ss_hi(0);
        n_vec++;
        if ({busy[0], rxv[0]} !== 2'b00 || rxv_rise[0] != r0c) begin
            n_err++;
            $display("FAIL abort: busy/rx_valid %b sets %0d required 00 0", {busy[0], rxv[0]}, rxv_rise[0] - r0c);
        end
        ss_lo(0);
        exp_q.push_back(32'h1234);
        xfer(0, 32'h1234, 16, got);
        cycles(6);
        exp = exp_q.pop_front();
        n_vec++;
        if (rxv[0] !== 1'b1 || rx_of(0) !== exp) begin
            n_err++;
            $display("FAIL abort_next: valid %b word %h required 1 %h", rxv[0], rx_of(0), exp);
        end
        ss_hi(0);
        do_ack(0);
    endtask

    task automatic test_back_to_back;
        logic [31:0] got, exp;
        logic exp_ovr;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
        exp_ovr = 1'b1;
`else
        exp_ovr = 1'b0;
`endif
        ss_lo(2);
        exp_q.push_back(32'h11);
        xfer(2, 32'h11, 8, got);
        cycles(6);
        exp = exp_q.pop_front();
        n_vec++;
        if (rxv[2] !== 1'b1 || rx_of(2) !== exp || ovr[2] !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_first: valid %b word %h ovr %b required 1 %h 0", rxv[2], rx_of(2), ovr[2], exp);
        end
        exp_q.push_back(32'h22);
        xfer(2, 32'h22, 8, got);
        cycles(6);
        exp = exp_q.pop_front();
        n_vec++;
        if (rxv[2] !== 1'b1 || rx_of(2) !== exp) begin
            n_err++;
            $display("FAIL b2b_second: valid %b word %h required 1 %h", rxv[2], rx_of(2), exp);
        end
        n_vec++;
        if (ovr[2] !== exp_ovr) begin
            n_err++;
            $display("FAIL b2b_overrun: got %b required %b", ovr[2], exp_ovr);
        end
        do_ack(2);
        n_vec++;
        if ({rxv[2], ovr[2]} !== 2'b00) begin
            n_err++;
            $display("FAIL b2b_ack: valid/ovr %b required 00", {rxv[2], ovr[2]});
        end
        ss_hi(2);
    endtask

    task automatic test_reset_mid;
        logic [31:0] got, exp;
        load_tx(0, 16'hBEEF);
        ss_lo(0);
        xfer(0, 32'hFFFF, 5, got);
        i_rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy[0], miso_oe[0], miso[0], rxv[0], txu[0], txr[0]} !== 6'b000001) begin
            n_err++;
            $display("FAIL reset_mid: busy/oe/miso/rxv/txu/txr %b required 000001", {busy[0], miso_oe[0], miso[0], rxv[0], txu[0], txr[0]});
        end
        cycles(2);
        i_rst_n = 1'b1;
        cycles(4);
        xfer(0, 32'hFFFF, 16, got);
        cycles(6);
        n_vec++;
        if ({busy[0], rxv[0]} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_no_start: busy/rx_valid %b required 00", {busy[0], rxv[0]});
        end
        ss_hi(0);
        ss_lo(0);
        exp_q.push_back(32'h5AA5);
        xfer(0, 32'h5AA5, 16, got);
        cycles(6);
        exp = exp_q.pop_front();
        n_vec++;
        if (rxv[0] !== 1'b1 || rx_of(0) !== exp) begin
            n_err++;
            $display("FAIL reset_recover: valid %b word %h required 1 %h", rxv[0], rx_of(0), exp);
        end
        ss_hi(0);
        do_ack(0);
    endtask

    initial begin
        cycles(1);
        test_reset();
        test_mode(0);
        test_mode(1);
        test_underrun();
        test_ss_abort();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
